dbgcmd01a: RTL
==============

// Module: dbgcmd01a
// PURPOSE
//  Debug command engine on the far side of the RS232 IO block: consumes received bytes (RxData/RxStatus/RxFetch),
//  decodes a 3-byte write / 2-byte read command protocol, drives an 8-bit register bus, and returns reply bytes
//  through the Tx handshake (TxData/TxStart/TxStatus). Also owns the Tx/Rx bit-rate selects fed to the IO block.
// PARAMETERS
//  P_BITRATE_DEF  8'h33    reset value of bit-rate register {Rx[7:4],Tx[3:0]}
//  P_TIMEOUT      24'd2_500_000  RSClk cycles allowed between bytes of one frame before abort
// PORTS
//  pavsv01a2dbgcmd01aRSClk     in   1  single clock, all logic posedge
//  pavsv01a2dbgcmd01aReset_n   in   1  synchronous, active-low reset
//  rsio_01a2dbgcmd01aRxData    in   8  received byte
//  rsio_01a2dbgcmd01aRxStatus  in   2  [0]=byte available, [1]=framing/overrun error on that byte
//  dbgcmd01a2rsio_01aRxFetch   out  1  1-cycle pulse: byte consumed
//  dbgcmd01a2rsio_01aTxData    out  8  byte to send, stable from TxStart until TxStatus returns low
//  dbgcmd01a2rsio_01aTxStart   out  1  1-cycle pulse, only issued while TxStatus=0
//  rsio_01a2dbgcmd01aTxStatus  in   1  1=transmitter busy
//  dbgcmd01a2rsio_01aTxBitRate out  4  bit-rate select, = rBitRate[3:0]
//  dbgcmd01a2rsio_01aRxBitRate out  4  bit-rate select, = rBitRate[7:4]
//  dbgcmd01a2regbusAddr        out  8  register address
//  dbgcmd01a2regbusWrData      out  8  write data
//  dbgcmd01a2regbusWr          out  1  1-cycle write strobe
//  dbgcmd01a2regbusRd          out  1  1-cycle read strobe
//  regbus2dbgcmd01aRdData      in   8  read data, valid exactly 1 cycle after Rd
// BEHAVIOUR
//  Reset: state IDLE; RxFetch/TxStart/Wr/Rd=0; Addr/WrData/TxData=8'h00; rBitRate=P_BITRATE_DEF; timer=0.
//  Protocol: 'W'(8'h57) A D -> write, reply 'K'(8'h4B). 'R'(8'h52) A -> read, reply data byte.
//   Other opcode -> reply '?'(8'h3F). Byte with RxStatus[1]=1 -> frame dropped, reply '!'(8'h21).
//  Byte intake (IDLE/GETADR/GETDAT): RxStatus[0]=1 -> latch RxData, pulse RxFetch same edge; next cycle is a
//   guard cycle (RxStatus ignored) so one byte is never consumed twice. Error byte is also fetched.
//  States/transitions:
//   IDLE  : 'W'/'R' -> GETADR (opcode latched); other -> TXSEND('?'); error -> TXSEND('!').
//   GETADR: byte -> Addr; opcode W -> GETDAT; opcode R -> BUSRD.
//   GETDAT: byte -> WrData; if Addr=8'hFF load rBitRate (no Wr strobe) else pulse Wr 1 cycle; -> TXSEND('K').
//   BUSRD : pulse Rd 1 cycle, capture RdData next cycle (latency 2 cycles in state) -> TXSEND(data).
//   TXSEND: when TxStatus=0 drive TxData, pulse TxStart -> TXARM. TxStatus=1 -> hold.
//   TXARM : 1 cycle, TxStatus ignored (transmitter acknowledge latency) -> TXWAIT.
//   TXWAIT: TxStatus=0 -> IDLE.
//  Read of Addr=8'hFF returns rBitRate locally, no Rd strobe.
//  Bit-rate change takes effect on the outputs the cycle after the load; 'K' is sent at the new rate (host rule).
//  Timeout: 24-bit timer counts in GETADR/GETDAT, clears on every fetched byte; reaching P_TIMEOUT -> IDLE,
//   no reply, no bus strobe. Timer saturates, never wraps.
//  Simultaneous: byte arriving during TXSEND/TXARM/TXWAIT is left unfetched until IDLE (IO block buffers it).
//  Wr and Rd never asserted together; at most one bus strobe per frame.
//  Reset asserted mid-frame or mid-transmit: all state to reset values next edge; TxStart never re-issued.
// STRUCTURE
//  Shared package dbgcmd01a_pkg: state encoding (IDLE..TXWAIT), opcode/reply byte constants, BITRATE_ADDR=8'hFF.
//  One sub-module natural: dbgcmd01a_txq (TXSEND/TXARM/TXWAIT handshake + TxData holding reg); rest flat.
// TESTING
//  'W',8'h10,8'hA5 -> Wr pulse 1 cycle with Addr=10,WrData=A5; then TxStart with TxData=8'h4B; exactly 3 RxFetch.
//  'R',8'h20, RdData=8'h3C -> Rd 1 cycle, TxData=8'h3C after 1-cycle latency; no Wr.
//  'W',8'hFF,8'h57 -> no Wr; TxBitRate=7,RxBitRate=5 next cycle; reply 8'h4B.
//  'X' -> reply 8'h3F; byte with RxStatus=2'b11 -> fetched, reply 8'h21, no bus strobe.
//  'W',8'h10 then silence > P_TIMEOUT (set 100 in bench) -> IDLE, no strobe/reply; next 'R' frame works.
//  TxStatus held 1 for 50 cycles at TXSEND -> TxStart delayed until low, single pulse; reset mid-TXWAIT -> outputs reset.

Source files
------------

// File: rtl/dbgcmd01a_pkg.sv
// Shared types and byte constants for the debug command engine.
// Imported by the command FSM and its transmit queue.
package dbgcmd01a_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GETADR,
    ST_GETDAT,
    ST_BUSRD,
    ST_TXSEND,
    ST_TXARM,
    ST_TXWAIT
  } state_t;

  localparam logic [7:0] OP_WR        = 8'h57;
  localparam logic [7:0] OP_RD        = 8'h52;
  localparam logic [7:0] RP_OK        = 8'h4B;
  localparam logic [7:0] RP_BADOP     = 8'h3F;
  localparam logic [7:0] RP_ERR       = 8'h21;
  localparam logic [7:0] BITRATE_ADDR = 8'hFF;

  function automatic logic is_op(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/dbgcmd01a_txq.sv
// Reply transmit handshake: holds the reply byte and issues one
// TxStart per load, then waits for the transmitter to go idle.
module dbgcmd01a_txq
  import dbgcmd01a_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       tx_status_i,
  output logic       busy_o,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o
);

  state_t     st_q, st_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q    <= ST_IDLE;
      data_q  <= 8'h00;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    data_d  = data_q;
    start_d = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (load_i) begin
          data_d = byte_i;
          st_d   = ST_TXSEND;
        end
      end
      ST_TXSEND: begin
        if (!tx_status_i) begin
          start_d = 1'b1;
          st_d    = ST_TXARM;
        end
      end
      // transmitter needs a cycle before busy reflects the start
      ST_TXARM:  st_d = ST_TXWAIT;
      ST_TXWAIT: begin
        if (!tx_status_i) st_d = ST_IDLE;
      end
      default:   st_d = ST_IDLE;
    endcase
  end

  assign busy_o     = (st_q != ST_IDLE);
  assign tx_data_o  = data_q;
  assign tx_start_o = start_q;

endmodule

// File: rtl/dbgcmd01a.sv
// Debug command engine: decodes W/R frames from the RS232 block,
// drives the register bus and queues one reply byte per frame.
module dbgcmd01a
  import dbgcmd01a_pkg::*;
#(
  parameter logic [7:0]  P_BITRATE_DEF = 8'h33,
  parameter logic [23:0] P_TIMEOUT     = 24'd2_500_000
) (
  input  logic       pavsv01a2dbgcmd01aRSClk,
  input  logic       pavsv01a2dbgcmd01aReset_n,
  input  logic [7:0] rsio_01a2dbgcmd01aRxData,
  input  logic [1:0] rsio_01a2dbgcmd01aRxStatus,
  output logic       dbgcmd01a2rsio_01aRxFetch,
  output logic [7:0] dbgcmd01a2rsio_01aTxData,
  output logic       dbgcmd01a2rsio_01aTxStart,
  input  logic       rsio_01a2dbgcmd01aTxStatus,
  output logic [3:0] dbgcmd01a2rsio_01aTxBitRate,
  output logic [3:0] dbgcmd01a2rsio_01aRxBitRate,
  output logic [7:0] dbgcmd01a2regbusAddr,
  output logic [7:0] dbgcmd01a2regbusWrData,
  output logic       dbgcmd01a2regbusWr,
  output logic       dbgcmd01a2regbusRd,
  input  logic [7:0] regbus2dbgcmd01aRdData
);

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;

  assign clk     = pavsv01a2dbgcmd01aRSClk;
  assign rst_n   = pavsv01a2dbgcmd01aReset_n;
  assign rx_data = rsio_01a2dbgcmd01aRxData;

  state_t      state_q, state_d;
  logic        opwr_q, opwr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  rate_q, rate_d;
  logic [23:0] tmr_q, tmr_d, tmr_inc;
  logic        fetch_q, fetch_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        ph_q, ph_d;
  logic        take, rx_err, intake;
  logic        load;
  logic [7:0]  rep;
  logic        tx_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opwr_q  <= 1'b0;
      addr_q  <= 8'h00;
      wdat_q  <= 8'h00;
      rate_q  <= P_BITRATE_DEF;
      tmr_q   <= 24'd0;
      fetch_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opwr_q  <= opwr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rate_q  <= rate_d;
      tmr_q   <= tmr_d;
      fetch_q <= fetch_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ph_q    <= ph_d;
    end
  end

  // fetch_q doubles as the guard cycle against double consumption
  assign intake = (state_q == ST_IDLE) || (state_q == ST_GETADR) ||
                  (state_q == ST_GETDAT);
  assign take   = intake & rsio_01a2dbgcmd01aRxStatus[0] & ~fetch_q;
  assign rx_err = rsio_01a2dbgcmd01aRxStatus[1];

  always_comb begin
    state_d = state_q;
    opwr_d  = opwr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rate_d  = rate_q;
    tmr_d   = 24'd0;
    fetch_d = take;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ph_d    = ph_q;
    load    = 1'b0;
    rep     = 8'h00;
    tmr_inc = (&tmr_q) ? tmr_q : tmr_q + 24'd1;
    if (state_q == ST_GETADR || state_q == ST_GETDAT) begin
      tmr_d = take ? 24'd0 : tmr_inc;
    end
    if (take && rx_err) begin
      load    = 1'b1;
      rep     = RP_ERR;
      state_d = ST_TXSEND;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (take && is_op(rx_data)) begin
            opwr_d  = (rx_data == OP_WR);
            state_d = ST_GETADR;
          end else if (take) begin
            load    = 1'b1;
            rep     = RP_BADOP;
            state_d = ST_TXSEND;
          end
        end
        ST_GETADR: begin
          if (take) begin
            addr_d = rx_data;
            if (opwr_q) begin
              state_d = ST_GETDAT;
            end else begin
              state_d = ST_BUSRD;
              ph_d    = 1'b0;
              rd_d    = (rx_data != BITRATE_ADDR);
            end
          end else if (tmr_inc >= P_TIMEOUT) begin
            state_d = ST_IDLE;
          end
        end
        ST_GETDAT: begin
          if (take) begin
            wdat_d = rx_data;
            if (addr_q == BITRATE_ADDR) rate_d = rx_data;
            else wr_d = 1'b1;
            load    = 1'b1;
            rep     = RP_OK;
            state_d = ST_TXSEND;
          end else if (tmr_inc >= P_TIMEOUT) begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSRD: begin
          ph_d = 1'b1;
          if (ph_q) begin
            ph_d    = 1'b0;
            load    = 1'b1;
            rep     = (addr_q == BITRATE_ADDR) ? rate_q
                                               : regbus2dbgcmd01aRdData;
            state_d = ST_TXSEND;
          end
        end
        ST_TXSEND: begin
          if (!tx_busy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  dbgcmd01a_txq u_txq (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .byte_i      (rep),
    .tx_status_i (rsio_01a2dbgcmd01aTxStatus),
    .busy_o      (tx_busy),
    .tx_data_o   (dbgcmd01a2rsio_01aTxData),
    .tx_start_o  (dbgcmd01a2rsio_01aTxStart)
  );

  assign dbgcmd01a2rsio_01aRxFetch   = fetch_q;
  assign dbgcmd01a2rsio_01aTxBitRate = rate_q[3:0];
  assign dbgcmd01a2rsio_01aRxBitRate = rate_q[7:4];
  assign dbgcmd01a2regbusAddr        = addr_q;
  assign dbgcmd01a2regbusWrData      = wdat_q;
  assign dbgcmd01a2regbusWr          = wr_q;
  assign dbgcmd01a2regbusRd          = rd_q;

endmodule
